// File: rtl/dea_pkg.sv
// Shared types and helpers for the cipher stream transmitter.
// Holds the FSM state encoding, default buffer depths and the per-byte cipher.
package dea_pkg;

    localparam int DATA_DEPTH_DEF = 100;
    localparam int KEY_DEPTH_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        SEND,
        WAIT_IDLE,
        DONE
    } state_t;

    // XOR with the key byte, then add the byte position; wraps mod 256.
    function automatic logic [7:0] cipher_byte(input logic [7:0] d,
                                               input logic [7:0] k,
                                               input logic [7:0] idx);
        return (d ^ k) + idx;
    endfunction

endpackage

// File: rtl/cipher_stream_tx.sv
// Buffers plaintext and key bytes, encrypts each byte with a cyclic key and
// streams the ciphertext over the UART_Sender Tx_Send/Tx_Busy handshake.
module cipher_stream_tx #(
    parameter int DATA_DEPTH = dea_pkg::DATA_DEPTH_DEF,
    parameter int KEY_DEPTH  = dea_pkg::KEY_DEPTH_DEF
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       clear,
    input  logic [7:0] load_data,
    input  logic       load_valid,
    input  logic       load_is_key,
    output logic       load_ready,
    input  logic       start,
    output logic [7:0] Tx_Data,
    output logic       Tx_Send,
    input  logic       Tx_Busy,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic [7:0] data_len,
    input  logic [7:0] rd_index,
    output logic [7:0] rd_data
);
    import dea_pkg::*;

    localparam int DW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int KW = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam logic [7:0] DATA_MAX = 8'(DATA_DEPTH);
    localparam logic [7:0] KEY_MAX  = 8'(KEY_DEPTH);

    state_t     r_state, w_next;
    logic [7:0] r_data   [DATA_DEPTH];
    logic [7:0] r_result [DATA_DEPTH];
    logic [7:0] r_key    [KEY_DEPTH];
    logic [7:0] r_data_len, r_key_len, r_idx, r_kidx;
    logic [7:0] r_d, r_k, r_tx_data;
    logic       r_tx_send, r_overflow;

    logic       w_idle, w_data_full, w_key_full, w_data_wr, w_key_wr, w_last;
    logic [7:0] w_len_next, w_cipher;

    assign w_idle      = (r_state == IDLE);
    assign w_data_full = (r_data_len == DATA_MAX);
    assign w_key_full  = (r_key_len == KEY_MAX);
    assign w_data_wr   = w_idle && !Reset && !clear && load_valid && !load_is_key && !w_data_full;
    assign w_key_wr    = w_idle && !Reset && !clear && load_valid &&  load_is_key && !w_key_full;
    // Length as it will be after this cycle's load/clear, so a start
    // arriving alongside a load sees the new byte.
    assign w_len_next  = clear ? 8'd0 : r_data_len + {7'd0, w_data_wr};
    assign w_last      = (r_idx == r_data_len - 8'd1);
    assign w_cipher    = cipher_byte(r_d, r_k, r_idx);

    always_ff @(posedge Clk_100M) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (start) w_next = (w_len_next != 8'd0) ? FETCH : DONE;
            FETCH:     w_next = CALC;
            CALC:      w_next = SEND;
            SEND:      if (Tx_Busy) w_next = WAIT_IDLE;
            WAIT_IDLE: if (!Tx_Busy) w_next = w_last ? DONE : FETCH;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Buffer storage carries no reset; only the lengths qualify it.
    always_ff @(posedge Clk_100M) begin
        if (w_data_wr) r_data[r_data_len[DW-1:0]] <= load_data;
        if (w_key_wr)  r_key[r_key_len[KW-1:0]]   <= load_data;
        if (!Reset && r_state == CALC) r_result[r_idx[DW-1:0]] <= w_cipher;
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            r_data_len <= 8'd0;
            r_key_len  <= 8'd0;
            r_idx      <= 8'd0;
            r_kidx     <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tx_send  <= 1'b0;
            r_overflow <= 1'b0;
            r_d        <= 8'd0;
            r_k        <= 8'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_data_len <= 8'd0;
                        r_key_len  <= 8'd0;
                        r_overflow <= 1'b0;
                    end else if (load_valid) begin
                        if ((load_is_key && w_key_full) || (!load_is_key && w_data_full))
                            r_overflow <= 1'b1;
                        if (w_data_wr) r_data_len <= r_data_len + 8'd1;
                        if (w_key_wr)  r_key_len  <= r_key_len + 8'd1;
                    end
                    if (start) begin
                        r_idx  <= 8'd0;
                        r_kidx <= 8'd0;
                    end
                end
                FETCH: begin
                    r_d <= r_data[r_idx[DW-1:0]];
                    r_k <= (r_key_len == 8'd0) ? 8'd0 : r_key[r_kidx[KW-1:0]];
                end
                CALC: begin
                    r_tx_data <= w_cipher;
                    r_tx_send <= 1'b1;
                end
                SEND:
                    if (Tx_Busy) r_tx_send <= 1'b0;
                WAIT_IDLE:
                    if (!Tx_Busy && !w_last) begin
                        r_idx  <= r_idx + 8'd1;
                        r_kidx <= (r_key_len == 8'd0 || r_kidx == r_key_len - 8'd1) ? 8'd0 : r_kidx + 8'd1;
                    end
                default: ;
            endcase
        end
    end

    assign Tx_Data    = r_tx_data;
    assign Tx_Send    = r_tx_send;
    assign busy       = !w_idle;
    assign done       = (r_state == DONE);
    assign load_ready = w_idle;
    assign overflow   = r_overflow;
    assign data_len   = r_data_len;
    assign rd_data    = (rd_index < r_data_len) ? r_result[rd_index[DW-1:0]] : 8'd0;

endmodule
